// File: rtl/zap_wb_drain_pkg.sv
// Shared definitions for the FIFO-to-Wishbone drain engine: entry layout, FSM states and
// the constant cycle-type identifier.
package zap_wb_drain_pkg;

  localparam int unsigned EntryW = 69;
  localparam int unsigned WeBit  = 68;
  localparam int unsigned SelLsb = 64;
  localparam int unsigned AdrLsb = 32;
  localparam int unsigned DatLsb = 0;

  localparam logic [2:0] CtiEndOfBurst = 3'b111;

  typedef enum logic {
    StIdle,
    StBus
  } state_e;

endpackage

// File: rtl/zap_wb_drain.sv
// Drains a FWFT FIFO of {we, sel, adr, dat} entries onto a Wishbone B3 classic bus, one
// single-beat transfer per entry, with a per-transfer timeout.
module zap_wb_drain
  import zap_wb_drain_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [EntryW-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_fifo_ack,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [3:0]        o_wb_sel,
  output logic [31:0]       o_wb_adr,
  output logic [31:0]       o_wb_dat,
  output logic [2:0]        o_wb_cti,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [31:0]       i_wb_dat,
  output logic [31:0]       o_rd_data,
  output logic              o_rd_valid,
  output logic              o_err,
  output logic              o_busy
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;
  logic        term;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    term       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!i_fifo_empty) begin
          we_d    = i_fifo_data[WeBit];
          sel_d   = i_fifo_data[SelLsb +: 4];
          adr_d   = i_fifo_data[AdrLsb +: 32];
          dat_d   = i_fifo_data[DatLsb +: 32];
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // ack wins over err, err over timeout
        if (i_wb_ack) begin
          term = 1'b1;
          if (!we_q) begin
            rd_data_d  = i_wb_dat;
            rd_valid_d = 1'b1;
          end
        end else if (i_wb_err || (cnt_q == TimeoutLast)) begin
          term  = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (term) begin
          cyc_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign o_fifo_ack = term & ~i_reset;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = cyc_q;
  assign o_wb_we    = we_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_cti   = CtiEndOfBurst;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_zap_wb_drain.sv
// Directed bench for zap_wb_drain: FIFO model, responding slave, and a scoreboard of
// expected bus transfers checked by a bus monitor.
module tb_zap_wb_drain;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [68:0] i_fifo_data = '0;
  logic        i_fifo_empty = 1'b1;
  logic        o_fifo_ack;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [2:0]  o_wb_cti;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_err, o_busy;

  zap_wb_drain #(.TIMEOUT(32'd8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_ack   (o_fifo_ack),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_sel     (o_wb_sel),
    .o_wb_adr     (o_wb_adr),
    .o_wb_dat     (o_wb_dat),
    .o_wb_cti     (o_wb_cti),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err),
    .i_wb_dat     (i_wb_dat),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // outcome: 0 none, 1 read data, 2 error
  typedef struct {
    logic [68:0] e;
    int          len;
    bit          b2b;
    bit          aborted;
    int          outcome;
    logic [31:0] rd;
  } exp_t;

  logic [68:0] fifo[$];
  exp_t        exp_bus[$];

  // FIFO model: pop on ack, present head shortly after each edge
  always @(posedge i_clk) begin
    if (o_fifo_ack && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    i_fifo_empty = (fifo.size() == 0);
    i_fifo_data  = (fifo.size() == 0) ? 69'h0 : fifo[0];
  end

  // Slave: resp_kind 0 silent, 1 ack, 2 err, 3 ack+err; responds resp_delay cycles into cyc
  int          resp_kind = 0;
  int          resp_delay = 0;
  logic [31:0] resp_dat = '0;
  int          scnt = 0;
  bit          sseen = 0;
  always @(posedge i_clk) begin
    #1;
    if (o_wb_cyc) begin
      scnt  = sseen ? scnt + 1 : 0;
      sseen = 1;
      i_wb_ack = (scnt == resp_delay) && (resp_kind == 1 || resp_kind == 3);
      i_wb_err = (scnt == resp_delay) && (resp_kind == 2 || resp_kind == 3);
      i_wb_dat = resp_dat;
    end else begin
      sseen    = 0;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
    end
  end

  // Bus monitor
  bit   cyc_prev = 0;
  int   n = 0, gap = 100, ack_cnt = 0, ack_pos = -1;
  exp_t cur;
  always @(negedge i_clk) begin
    if (o_wb_cyc) begin
      if (!cyc_prev) begin
        chk("unexpected_txn", 69'(exp_bus.size() > 0), 69'd1);
        if (exp_bus.size() > 0) cur = exp_bus.pop_front();
        if (cur.b2b) chk("idle_gap", 69'(gap), 69'd1);
        chk("cti", 69'(o_wb_cti), 69'h7);
        n = 0;
        ack_cnt = 0;
        ack_pos = -1;
      end
      chk("bus_fields", {o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat}, cur.e);
      chk("stb", 69'(o_wb_stb), 69'd1);
      chk("busy", 69'(o_busy), 69'd1);
      if (o_fifo_ack) begin
        ack_cnt++;
        ack_pos = n;
      end
      n++;
    end else begin
      if (cyc_prev) begin
        chk("cyc_len", 69'(n), 69'(cur.len));
        chk("pop_count", 69'(ack_cnt), cur.aborted ? 69'd0 : 69'd1);
        if (!cur.aborted) chk("pop_pos", 69'(ack_pos), 69'(cur.len - 1));
        chk("rd_valid", 69'(o_rd_valid), 69'(cur.outcome == 1));
        chk("err_pulse", 69'(o_err), 69'(cur.outcome == 2));
        if (cur.outcome == 1) chk("rd_data", 69'(o_rd_data), 69'(cur.rd));
        gap = 1;
      end else begin
        gap++;
        if (o_rd_valid || o_err || o_fifo_ack)
          chk("idle_quiet", {o_rd_valid, o_err, o_fifo_ack}, 69'd0);
      end
      chk("busy_idle", 69'(o_busy), 69'd0);
    end
    cyc_prev = o_wb_cyc;
  end

  task automatic expect_txn(input logic [68:0] e, input int len, input bit b2b,
                            input bit aborted, input int outcome, input logic [31:0] rd);
    exp_t x;
    x.e = e; x.len = len; x.b2b = b2b; x.aborted = aborted; x.outcome = outcome; x.rd = rd;
    exp_bus.push_back(x);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_bus.size() != 0 || o_wb_cyc || fifo.size() != 0) && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    chk(tag, 69'(k < 200), 69'd1);
    repeat (3) @(negedge i_clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [68:0] e;
  initial begin
    #2;
    chk("rst_ctrl", {o_wb_cyc, o_wb_stb, o_wb_we, o_rd_valid, o_err, o_busy, o_fifo_ack}, 69'd0);
    chk("rst_data", {o_wb_sel, o_wb_adr, o_wb_dat}, 69'd0);
    chk("rst_rd_data", 69'(o_rd_data), 69'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // write, ack two cycles after stb
    resp_kind = 1; resp_delay = 2;
    e = {1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF};
    expect_txn(e, 3, 0, 0, 0, 32'h0);
    fifo.push_back(e);
    drain("drain_write");

    // read
    resp_kind = 1; resp_delay = 1; resp_dat = 32'hCAFE_F00D;
    e = {1'b0, 4'h3, 32'h0000_0020, 32'h0};
    expect_txn(e, 2, 0, 0, 1, 32'hCAFE_F00D);
    fifo.push_back(e);
    drain("drain_read");

    // four queued writes with immediate acks
    resp_kind = 1; resp_delay = 0; resp_dat = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, 4'(i + 1), 32'h0000_4000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i)};
      expect_txn(e, 1, i != 0, 0, 0, 32'h0);
      fifo.push_back(e);
    end
    drain("drain_b2b");
    chk("rd_data_hold", 69'(o_rd_data), 69'(32'hCAFE_F00D));

    // timeout with no response
    resp_kind = 0;
    e = {1'b1, 4'h1, 32'h0000_0BAD, 32'h1234_5678};
    expect_txn(e, 8, 0, 0, 2, 32'h0);
    fifo.push_back(e);
    drain("drain_timeout");
    chk("timeout_discard", 69'(fifo.size()), 69'd0);

    // bus error on a write
    resp_kind = 2; resp_delay = 1;
    e = {1'b1, 4'h8, 32'h0000_0C00, 32'h0BAD_0BAD};
    expect_txn(e, 2, 0, 0, 2, 32'h0);
    fifo.push_back(e);
    drain("drain_err");

    // simultaneous ack and err on a read
    resp_kind = 3; resp_delay = 0; resp_dat = 32'h7654_3210;
    e = {1'b0, 4'hF, 32'h0000_0D00, 32'h0};
    expect_txn(e, 1, 0, 0, 1, 32'h7654_3210);
    fifo.push_back(e);
    drain("drain_ackerr");

    // reset in the third bus cycle, entry reissued afterwards
    resp_kind = 0;
    e = {1'b1, 4'h5, 32'h0000_0E00, 32'hFEED_FACE};
    expect_txn(e, 3, 0, 1, 0, 32'h0);
    expect_txn(e, 2, 0, 0, 0, 32'h0);
    fifo.push_back(e);
    begin
      int k = 0;
      while (!o_wb_cyc && k < 20) begin
        @(negedge i_clk);
        k++;
      end
      chk("rst_wait_cyc", 69'(k < 20), 69'd1);
    end
    repeat (2) @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    chk("midrst_cyc_stb", {o_wb_cyc, o_wb_stb, o_fifo_ack, o_busy}, 69'd0);
    resp_kind = 1; resp_delay = 1;
    repeat (2) @(negedge i_clk);
    chk("midrst_no_pop", 69'(fifo.size()), 69'd1);
    i_reset = 1'b0;
    drain("drain_reissue");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
